// File: rtl/ch_frame_reader.sv
// Reads four virtual-channel buffers out as one framed word stream. Each channel
// is preceded by a header word, and the stream uses valid/ready flow control.
module ch_frame_reader #(
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_ready,
  input  logic [15:0] i_out_size,
  input  logic [7:0]  i_data_count,
  input  logic [31:0] i_rd_data,
  input  logic        i_rdy,
  output logic [1:0]  o_rd_vchn,
  output logic [7:0]  o_rd_addr,
  output logic [31:0] o_data,
  output logic        o_vld,
  output logic        o_sop,
  output logic        o_eop,
  output logic [15:0] o_frame_len,
  output logic        o_busy,
  output logic        o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_HDR,
    S_ADDR,
    S_WAIT,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic        sync_meta;
  logic        sync_lvl;
  logic        sync_prev;
  logic [1:0]  settle;
  logic        primed;
  logic        start_evt;
  logic [7:0]  cnt;
  logic [1:0]  wait_cnt;
  logic [31:0] data_q;
  logic        xfer;
  logic        last_word;
  logic        last_chan;
  logic        cnt_nz;

  // Edge detection stays disabled until the delay line has refilled after reset.
  // This way a level that is already high at release is not treated as a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
      sync_prev <= 1'b0;
      settle    <= 2'd0;
    end else begin
      sync_meta <= i_frame_ready;
      sync_lvl  <= sync_meta;
      sync_prev <= sync_lvl;
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end
    end
  end

  assign primed    = (settle == 2'd3);
  assign start_evt = primed & sync_lvl & ~sync_prev;

  assign xfer      = o_vld & i_rdy;
  assign cnt_nz    = (cnt != 8'd0);
  assign last_chan = (o_rd_vchn == 2'd3);
  // Widen to 9 bits so that a count of 255 ends at address 254 without wrapping.
  assign last_word = (({1'b0, o_rd_addr} + 9'd1) >= {1'b0, cnt});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    o_vld      = 1'b0;
    o_sop      = 1'b0;
    o_eop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_evt) begin
          next_state = S_SEL;
        end
      end
      S_SEL: begin
        next_state = S_HDR;
      end
      S_HDR: begin
        o_vld = 1'b1;
        o_sop = (o_rd_vchn == 2'd0);
        o_eop = last_chan & ~cnt_nz;
        if (xfer) begin
          if (cnt_nz) begin
            next_state = S_ADDR;
          end else if (last_chan) begin
            next_state = S_DONE;
          end else begin
            next_state = S_SEL;
          end
        end
      end
      S_ADDR: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == 2'd0) begin
          next_state = S_DATA;
        end
      end
      S_DATA: begin
        o_vld = 1'b1;
        o_eop = last_chan & last_word;
        if (xfer) begin
          if (!last_word) begin
            next_state = S_ADDR;
          end else if (last_chan) begin
            next_state = S_DONE;
          end else begin
            next_state = S_SEL;
          end
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_vchn   <= 2'd0;
      o_rd_addr   <= 8'd0;
      cnt         <= 8'd0;
      wait_cnt    <= 2'd0;
      data_q      <= 32'd0;
      o_frame_len <= 16'd0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (start_evt) begin
        if (state == S_IDLE) begin
          o_frame_len <= i_out_size;
          o_busy      <= 1'b1;
          o_rd_vchn   <= 2'd0;
        end else begin
          o_overrun <= 1'b1;
        end
      end

      if (state == S_SEL) begin
        cnt    <= i_data_count;
        data_q <= {8'hA5, 6'd0, o_rd_vchn, 8'h00, i_data_count};
      end

      if (state == S_HDR && xfer && cnt_nz) begin
        o_rd_addr <= 8'd0;
      end
      if (state == S_DATA && xfer && !last_word) begin
        o_rd_addr <= o_rd_addr + 8'd1;
      end

      if (((state == S_HDR && !cnt_nz) || (state == S_DATA && last_word))
          && xfer && !last_chan) begin
        o_rd_vchn <= o_rd_vchn + 2'd1;
      end

      if (state == S_ADDR) begin
        wait_cnt <= WAIT_LAST;
      end else if (state == S_WAIT && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end

      if (state == S_WAIT && wait_cnt == 2'd0) begin
        data_q <= i_rd_data;
      end

      if (state == S_DONE) begin
        o_busy <= 1'b0;
      end
    end
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_ch_frame_reader.sv
// Self-checking bench for ch_frame_reader. Three instances are built, with read latencies 2, 1 and 4.
// Each instance is checked against a frame model and a latency-accurate channel memory model.
module tb_ch_frame_reader;

  typedef logic [33:0] rec_t;
  typedef rec_t rec_q_t [$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_ready = 1'b0;
  logic [15:0] out_size = 16'd0;
  logic        rdy = 1'b1;
  logic [7:0]  counts [4];
  logic [31:0] mem_seed = 32'd0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [1:0] v, input logic [7:0] a);
    return mem_seed ^ {6'd0, v, a, ~a, a + {6'd0, v}};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [1:0]  rd_vchn;
    logic [7:0]  rd_addr;
    logic [31:0] data;
    logic        vld;
    logic        sop;
    logic        eop;
    logic [15:0] frame_len;
    logic        busy;
    logic        overrun;
    logic [31:0] pipe [LAT];
    rec_t        rec [$];

    ch_frame_reader #(.RD_LATENCY(LAT)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_ready(frame_ready),
      .i_out_size   (out_size),
      .i_data_count (counts[rd_vchn]),
      .i_rd_data    (pipe[LAT-1]),
      .i_rdy        (rdy),
      .o_rd_vchn    (rd_vchn),
      .o_rd_addr    (rd_addr),
      .o_data       (data),
      .o_vld        (vld),
      .o_sop        (sop),
      .o_eop        (eop),
      .o_frame_len  (frame_len),
      .o_busy       (busy),
      .o_overrun    (overrun)
    );

    // The read data becomes valid exactly LAT clocks after the address changes.
    always @(posedge clk) begin
      pipe[0] <= mem_word(rd_vchn, rd_addr);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    always @(negedge clk) begin
      if (vld && rdy) rec.push_back({sop, eop, data});
    end
  end

  function automatic logic [34:0] snap(input int d);
    case (d)
      0: return {g_dut[0].vld, g_dut[0].sop, g_dut[0].eop, g_dut[0].data};
      1: return {g_dut[1].vld, g_dut[1].sop, g_dut[1].eop, g_dut[1].data};
      default: return {g_dut[2].vld, g_dut[2].sop, g_dut[2].eop, g_dut[2].data};
    endcase
  endfunction

  // Format: {busy, overrun, frame_len, rd_vchn, rd_addr}.
  function automatic logic [27:0] status(input int d);
    case (d)
      0: return {g_dut[0].busy, g_dut[0].overrun, g_dut[0].frame_len, g_dut[0].rd_vchn, g_dut[0].rd_addr};
      1: return {g_dut[1].busy, g_dut[1].overrun, g_dut[1].frame_len, g_dut[1].rd_vchn, g_dut[1].rd_addr};
      default: return {g_dut[2].busy, g_dut[2].overrun, g_dut[2].frame_len, g_dut[2].rd_vchn, g_dut[2].rd_addr};
    endcase
  endfunction

  function automatic rec_q_t get_rec(input int d);
    case (d)
      0: return g_dut[0].rec;
      1: return g_dut[1].rec;
      default: return g_dut[2].rec;
    endcase
  endfunction

  function automatic rec_q_t build_expected();
    rec_q_t q;
    for (int v = 0; v < 4; v++) begin
      q.push_back({v == 0, (v == 3) && (counts[v] == 8'd0), 8'hA5, 6'd0, 2'(v), 8'h00, counts[v]});
      for (int a = 0; a < int'(counts[v]); a++)
        q.push_back({1'b0, (v == 3) && (a == int'(counts[v]) - 1), mem_word(2'(v), 8'(a))});
    end
    return q;
  endfunction

  task automatic clear_recs();
    g_dut[0].rec.delete();
    g_dut[1].rec.delete();
    g_dut[2].rec.delete();
  endtask

  task automatic set_frame(input int c0, input int c1, input int c2, input int c3);
    counts[0] = 8'(c0);
    counts[1] = 8'(c1);
    counts[2] = 8'(c2);
    counts[3] = 8'(c3);
    out_size  = 16'(4 + c0 + c1 + c2 + c3);
    mem_seed  = $urandom;
    clear_recs();
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1 frame_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 frame_ready = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_rdy, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge clk);
      #1;
      if (rand_rdy) rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!g_dut[0].busy && !g_dut[1].busy && !g_dut[2].busy) ok = 1'b1;
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset();
    logic [27:0] st;
    logic [34:0] sn;
    rdy = 1'b1;
    frame_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sn = snap(d);
      st = status(d);
      total++;
      if (sn !== 35'd0) begin
        bad++;
        $display("FAIL reset_stream dut%0d: got %h expected 0", d, sn);
      end
      total++;
      if (st !== 28'd0) begin
        bad++;
        $display("FAIL reset_status dut%0d: got %h expected 0", d, st);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      st = status(d);
      sn = snap(d);
      total++;
      if (st[27] !== 1'b0 || sn[34] !== 1'b0 || get_rec(d).size() != 0) begin
        bad++;
        $display("FAIL reset_high_level dut%0d: got busy=%b vld=%b expected busy=0 vld=0", d, st[27], sn[34]);
      end
    end
    frame_ready = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_mixed_counts();
    rec_q_t exp;
    rec_q_t act;
    logic [27:0] st;
    bit ok;
    rdy = 1'b1;
    set_frame(3, 0, 255, 1);
    start_frame();
    wait_done(5000, 1'b0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mixed_timeout: got busy still set expected idle");
    end
    exp = build_expected();
    for (int d = 0; d < 3; d++) begin
      act = get_rec(d);
      st = status(d);
      total++;
      if (act.size() != 263) begin
        bad++;
        $display("FAIL mixed_len dut%0d: got %0d words expected 263", d, act.size());
      end else begin
        for (int i = 0; i < 263; i++) begin
          total++;
          if (act[i] !== exp[i]) begin
            bad++;
            $display("FAIL mixed_word dut%0d[%0d]: got %h expected %h", d, i, act[i], exp[i]);
          end
        end
        total++;
        if (act[0] !== {2'b10, 32'hA5000003} || act[4][31:0] !== 32'hA5010000 ||
            act[5][31:0] !== 32'hA50200FF || act[261][31:0] !== 32'hA5030001 ||
            act[262][33:32] !== 2'b01) begin
          bad++;
          $display("FAIL mixed_headers dut%0d: got %h %h %h %h eop=%b", d, act[0], act[4], act[5], act[261], act[262][32]);
        end
      end
      total++;
      if (st[25:10] !== 16'd263 || st[26] !== 1'b0) begin
        bad++;
        $display("FAIL mixed_len_ovr dut%0d: got len=%0d ovr=%b expected len=263 ovr=0", d, st[25:10], st[26]);
      end
    end
  endtask

  task automatic test_all_zero();
    rec_q_t act;
    logic [27:0] st;
    bit ok;
    rdy = 1'b1;
    set_frame(0, 0, 0, 0);
    start_frame();
    wait_done(500, 1'b0, ok);
    for (int d = 0; d < 3; d++) begin
      act = get_rec(d);
      st = status(d);
      total++;
      if (act.size() != 4) begin
        bad++;
        $display("FAIL zero_len dut%0d: got %0d words expected 4", d, act.size());
      end else begin
        total++;
        if (act[0] !== {2'b10, 32'hA5000000} || act[1] !== {2'b00, 32'hA5010000} ||
            act[2] !== {2'b00, 32'hA5020000} || act[3] !== {2'b01, 32'hA5030000}) begin
          bad++;
          $display("FAIL zero_words dut%0d: got %h %h %h %h", d, act[0], act[1], act[2], act[3]);
        end
      end
      total++;
      if (!ok || st[27] !== 1'b0) begin
        bad++;
        $display("FAIL zero_busy dut%0d: got busy=%b expected 0", d, st[27]);
      end
    end
  endtask

  task automatic test_random_stall();
    rec_q_t exp;
    rec_q_t act;
    logic [34:0] prev [3];
    logic [34:0] cur;
    bit prev_stall [3];
    bit done;
    rdy = 1'b0;
    set_frame(2, 2, 2, 2);
    for (int d = 0; d < 3; d++) prev_stall[d] = 1'b0;
    start_frame();
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge clk);
      #1 rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        cur = snap(d);
        if (prev_stall[d]) begin
          total++;
          if (cur !== prev[d]) begin
            bad++;
            $display("FAIL stall_stable dut%0d: got %h expected %h", d, cur, prev[d]);
          end
        end
        prev_stall[d] = cur[34] && !rdy;
        prev[d] = cur;
      end
      done = !g_dut[0].busy && !g_dut[1].busy && !g_dut[2].busy;
    end
    rdy = 1'b1;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL stall_timeout: got busy still set expected idle");
    end
    exp = build_expected();
    for (int d = 0; d < 3; d++) begin
      act = get_rec(d);
      total++;
      if (act.size() != 12) begin
        bad++;
        $display("FAIL stall_len dut%0d: got %0d words expected 12", d, act.size());
      end else begin
        for (int i = 0; i < 12; i++) begin
          total++;
          if (act[i] !== exp[i]) begin
            bad++;
            $display("FAIL stall_word dut%0d[%0d]: got %h expected %h", d, i, act[i], exp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random_frames();
    rec_q_t exp;
    rec_q_t act;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      set_frame($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
      start_frame();
      wait_done(3000, 1'b1, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rand_timeout it%0d: got busy still set expected idle", it);
      end
      exp = build_expected();
      for (int d = 0; d < 3; d++) begin
        act = get_rec(d);
        total++;
        if (act.size() != exp.size()) begin
          bad++;
          $display("FAIL rand_len dut%0d it%0d: got %0d words expected %0d", d, it, act.size(), exp.size());
        end else begin
          for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (act[i] !== exp[i]) begin
              bad++;
              $display("FAIL rand_word dut%0d it%0d[%0d]: got %h expected %h", d, it, i, act[i], exp[i]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_overrun();
    rec_q_t exp;
    rec_q_t act;
    logic [27:0] st;
    bit ok;
    rdy = 1'b1;
    set_frame(6, 5, 4, 3);
    start_frame();
    repeat (6) @(posedge clk);
    #1 frame_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 frame_ready = 1'b0;
    wait_done(2000, 1'b0, ok);
    repeat (30) @(posedge clk);
    @(negedge clk);
    exp = build_expected();
    for (int d = 0; d < 3; d++) begin
      act = get_rec(d);
      st = status(d);
      total++;
      if (!ok || st[26] !== 1'b1 || st[27] !== 1'b0) begin
        bad++;
        $display("FAIL overrun_flag dut%0d: got ovr=%b busy=%b expected ovr=1 busy=0", d, st[26], st[27]);
      end
      total++;
      if (act.size() != exp.size()) begin
        bad++;
        $display("FAIL overrun_len dut%0d: got %0d words expected %0d", d, act.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          total++;
          if (act[i] !== exp[i]) begin
            bad++;
            $display("FAIL overrun_word dut%0d[%0d]: got %h expected %h", d, i, act[i], exp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    rec_q_t exp;
    rec_q_t act;
    logic [27:0] st;
    logic [34:0] sn;
    bit found;
    bit ok;
    rdy = 1'b1;
    set_frame(4, 4, 4, 4);
    start_frame();
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      if (g_dut[0].rec.size() >= 3 && g_dut[0].vld && !g_dut[0].sop) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midreset_timeout: got no data word expected one");
    end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      sn = snap(d);
      st = status(d);
      total++;
      if (sn[34] !== 1'b0 || st[27] !== 1'b0 || st[26] !== 1'b0) begin
        bad++;
        $display("FAIL midreset_clear dut%0d: got vld=%b busy=%b ovr=%b expected 0", d, sn[34], st[27], st[26]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    set_frame($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 9));
    start_frame();
    wait_done(3000, 1'b0, ok);
    exp = build_expected();
    for (int d = 0; d < 3; d++) begin
      act = get_rec(d);
      total++;
      if (!ok || act.size() != exp.size()) begin
        bad++;
        $display("FAIL midreset_len dut%0d: got %0d words expected %0d", d, act.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          total++;
          if (act[i] !== exp[i]) begin
            bad++;
            $display("FAIL midreset_word dut%0d[%0d]: got %h expected %h", d, i, act[i], exp[i]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int v = 0; v < 4; v++) counts[v] = 8'd0;
    test_reset();
    test_mixed_counts();
    test_all_zero();
    test_random_stall();
    test_random_frames();
    test_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch_frame_reader.md
CH_FRAME_READER -- requirements
Module: ch_frame_reader

Interface
REQ-001 Parameter RD_LATENCY, default 2: cycles from an o_rd_addr/o_rd_vchn change to valid i_rd_data; legal range 1..4.
REQ-002 clk  in  1  single clock for all logic (channel memory read clock).
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 i_frame_ready  in  1  frame-complete level from the channel stage, asynchronous to clk.
REQ-005 i_out_size  in  16  total frame words (4 headers + sum of channel counts).
REQ-006 i_data_count  in  8  word count of the channel selected by o_rd_vchn, combinational from o_rd_vchn.
REQ-007 i_rd_data  in  32  channel memory read data.
REQ-008 o_rd_vchn  out  2  virtual channel being read.
REQ-009 o_rd_addr  out  8  word address within the channel.
REQ-010 o_data  out  32  output stream word.
REQ-011 o_vld  out  1  o_data valid.
REQ-012 i_rdy  in  1  downstream ready; a word transfers when o_vld and i_rdy are both high on a clk edge.
REQ-013 o_sop / o_eop  out  1 each  first / last word of a frame.
REQ-014 o_frame_len  out  16  i_out_size latched at frame start.
REQ-015 o_busy  out  1  frame readout in progress.
REQ-016 o_overrun  out  1  sticky; a frame-ready rising edge arrived while busy.

Function
REQ-017 i_frame_ready passes through a 2-flop synchronizer; a start event is a rising edge on the synchronized level.
REQ-018 Start event in IDLE: latch i_out_size into o_frame_len, set o_busy=1, set o_rd_vchn=0, enter SEL.
REQ-019 Start event while o_busy=1: set o_overrun=1; the current frame continues unaffected and the event is discarded.
REQ-020 States: IDLE, SEL, HDR, ADDR, WAIT, DATA, DONE.
REQ-021 SEL lasts one cycle, then latches i_data_count as cnt and enters HDR.
REQ-022 HDR: o_vld=1, o_data={8'hA5, 6'd0, o_rd_vchn, 8'h00, cnt}; on transfer, go to ADDR if cnt!=0, else advance channel.
REQ-023 ADDR: drive o_rd_addr=word index (starting at 0), then enter WAIT for RD_LATENCY cycles.
REQ-024 After WAIT, capture i_rd_data into the output register and enter DATA with o_vld=1.
REQ-025 DATA: hold o_data and o_vld until transfer; on transfer, increment the index and go to ADDR if index+1<cnt, else advance channel.
REQ-026 Advance channel: if o_rd_vchn<3, increment it and go to SEL; if o_rd_vchn=3, go to DONE.
REQ-027 DONE lasts one cycle, clears o_busy, and returns to IDLE.
REQ-028 o_sop=1 only with the vchn-0 header word; o_eop=1 only with the last word of vchn 3 (its header if cnt=0).
REQ-029 o_vld is never high outside HDR or DATA; o_data and the flags stay stable while o_vld=1 and i_rdy=0.
REQ-030 A frame emits exactly 4 + sum(cnt) words; cnt=255 reads addresses 0..254 without 8-bit wrap; a mismatch with o_frame_len is not checked.
REQ-031 i_rdy held low stalls indefinitely with no word lost or duplicated.

Reset
REQ-032 On rst_n low, at any time including mid-frame: state=IDLE, all outputs 0, synchronizer and sticky flag cleared.
REQ-033 After reset release, a start event requires a fresh rising edge of the synchronized level; a level already high at release starts nothing.

Verification
REQ-034 Counts {3,0,255,1}, i_rdy=1, i_out_size=263 -> 263 words; headers 0xA5000003, 0xA5010000, 0xA50200FF, 0xA5030001; o_sop on word 0, o_eop on word 262; each data word equals the memory model at its address.
REQ-035 Counts {0,0,0,0} -> exactly 4 header words; o_eop on 0xA5030000; o_busy returns to 0.
REQ-036 Counts {2,2,2,2}, i_rdy random 50% -> 12 words in order, stable during stalls, no drop or duplicate.
REQ-037 Second i_frame_ready pulse mid-frame -> o_overrun=1, current frame completes intact, no second frame emitted.
REQ-038 rst_n pulsed low mid-DATA -> o_vld=0 and o_busy=0 immediately; the next frame after a rising edge is correct from o_sop.
REQ-039 Run with RD_LATENCY=1 and RD_LATENCY=4 -> data matches the memory model in both cases.
